// File: rtl/sa_result_drain.sv
// sa_result_drain: acknowledges SA core row results into ping-pong banks and streams them one row per handshake
module sa_result_drain #(
    parameter int ROWS = 8,
    parameter int DW = 32,
    localparam int RIW = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ROWS*DW-1:0] core_rout,
    input  logic [ROWS-1:0]    core_rvalid,
    output logic               core_outread,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [RIW-1:0]     out_row,
    output logic               out_last,
    output logic [15:0]        vec_count,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ACK, GUARD} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] data_q [2][ROWS];
    logic [ROWS-1:0] mask_q [2];
    logic [ROWS-1:0] rd_mask;
    logic [1:0] full_q;
    logic wr_ptr, rd_ptr, capture, pop, last;
    logic [RIW-1:0] sel;
    assign capture = state == IDLE && |core_rvalid && !full_q[wr_ptr];
    assign state_nxt = state == ACK ? GUARD : state == GUARD ? IDLE : capture ? ACK : IDLE;
    assign rd_mask = mask_q[rd_ptr];
    assign last = rd_mask != '0 && (rd_mask & (rd_mask - ROWS'(1))) == '0;
    assign out_valid = full_q[rd_ptr];
    assign pop = out_valid && out_ready;
    assign out_data = out_valid ? data_q[rd_ptr][sel] : '0;
    assign out_row = out_valid ? sel : '0;
    assign out_last = out_valid && last;
    assign core_outread = state == ACK;
    assign busy = |full_q || state != IDLE;
    always_comb begin
        sel = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            sel = rd_mask[i] ? RIW'(i) : sel;
    end
    always_ff @(posedge clk) begin
        if (capture)
            for (int r = 0; r < ROWS; r++)
                data_q[wr_ptr][r] <= core_rout[r*DW +: DW];
    end
    // capture and drain always target different banks, so both may update in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            full_q <= '0;
            mask_q[0] <= '0;
            mask_q[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            vec_count <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                mask_q[wr_ptr] <= core_rvalid;
                full_q[wr_ptr] <= 1'b1;
                wr_ptr <= ~wr_ptr;
                vec_count <= vec_count + 16'd1;
            end
            if (pop) begin
                mask_q[rd_ptr][sel] <= 1'b0;
                if (last) begin
                    full_q[rd_ptr] <= 1'b0;
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: directed scenarios against a behavioural core and stream sink
module tb_sa_result_drain;
    localparam int ROWS = 8;
    localparam int DW = 32;
    localparam int RIW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ROWS*DW-1:0] core_rout = '0;
    logic [ROWS-1:0] core_rvalid = '0;
    logic core_outread, out_valid, out_last, busy;
    logic out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [RIW-1:0] out_row;
    logic [15:0] vec_count;

    sa_result_drain #(.ROWS(ROWS), .DW(DW)) dut (
        .clk(clk), .rst(rst), .core_rout(core_rout), .core_rvalid(core_rvalid),
        .core_outread(core_outread), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_last(out_last),
        .vec_count(vec_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit core_en = 1'b0;
    logic [7:0] hold_rvalid = 8'h00;
    int ready_mode = 0;
    logic [7:0] vq_mask[$];
    logic [255:0] vq_data[$];
    int rx_row[$];
    logic [31:0] rx_data[$];
    bit rx_last[$];
    int last_cyc[$];
    int pulse_cyc[$];
    int n_pulse = 0;
    int cyc = 0;
    int stall_err = 0;
    int stall_cnt = 0;
    bit prev_stall = 1'b0;
    logic [31:0] p_data;
    logic [2:0] p_row;
    logic p_last;

    // core model: presents one queued vector, drops rvalid when it sees outread
    always @(posedge clk) begin
        #1;
        if (!core_en) begin
            core_rvalid = hold_rvalid;
            core_rout = '0;
        end else if (core_outread) begin
            core_rvalid = '0;
        end else if (core_rvalid == '0 && vq_mask.size() > 0) begin
            core_rvalid = vq_mask.pop_front();
            core_rout = vq_data.pop_front();
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst && out_valid && out_ready) begin
            rx_row.push_back(int'(out_row));
            rx_data.push_back(out_data);
            rx_last.push_back(out_last);
            if (out_last) last_cyc.push_back(cyc);
        end
        if (core_outread) begin
            n_pulse++;
            pulse_cyc.push_back(cyc);
        end
        if (prev_stall && !rst) begin
            stall_cnt++;
            if (out_data !== p_data || out_row !== p_row || out_last !== p_last || out_valid !== 1'b1)
                stall_err++;
        end
        prev_stall = !rst && out_valid && !out_ready;
        p_data = out_data;
        p_row = out_row;
        p_last = out_last;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_vec(input logic [7:0] m, input logic [31:0] base);
        logic [255:0] d;
        for (int r = 0; r < ROWS; r++) d[r*32 +: 32] = base + 32'(r);
        vq_mask.push_back(m);
        vq_data.push_back(d);
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rx_row.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_chk++;
        if (rx_row.size() < n) $display("FAIL %s timeout: got %0d words, want %0d", name, rx_row.size(), n);
        else n_pass++;
    endtask

    task automatic test_reset();
        hold_rvalid = 8'hFF;
        core_en = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_chk++; if (core_outread !== 1'b0) $display("FAIL reset_outread: got %b want 0", core_outread); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (vec_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", vec_count); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (out_data !== 32'd0) $display("FAIL reset_data: got %0h want 0", out_data); else n_pass++;
        hold_rvalid = 8'h00;
        tick();
        rst = 1'b0;
        core_en = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int b, p0, k;
        b = rx_row.size();
        p0 = n_pulse;
        ready_mode = 1;
        tick();
        for (int r = 0; r < ROWS; r++) ;
        vq_mask.push_back(8'hFF);
        begin
            logic [255:0] d;
            for (int r = 0; r < ROWS; r++) d[r*32 +: 32] = 32'(r * 3);
            vq_data.push_back(d);
        end
        k = 0;
        while (!core_outread && k < 20) begin
            tick();
            k++;
        end
        n_chk++; if (core_outread !== 1'b1) $display("FAIL single_ack: got %b want 1", core_outread); else n_pass++;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL single_latency: out_valid %b want 1 with outread", out_valid); else n_pass++;
        wait_words(b + 8, 100, "single");
        repeat (5) tick();
        n_chk++; if (n_pulse - p0 !== 1) $display("FAIL single_pulses: got %0d want 1", n_pulse - p0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (rx_row[b+i] !== i || rx_data[b+i] !== 32'(i * 3) || rx_last[b+i] !== (i == 7))
                $display("FAIL single_word%0d: got row %0d data %0d last %b want row %0d data %0d last %b",
                         i, rx_row[b+i], rx_data[b+i], rx_last[b+i], i, i * 3, i == 7);
            else n_pass++;
        end
        n_chk++; if (vec_count !== 16'd1) $display("FAIL single_count: got %0d want 1", vec_count); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_sparse();
        int b, p0;
        int er[3] = '{2, 5, 7};
        b = rx_row.size();
        p0 = n_pulse;
        push_vec(8'b1010_0100, 32'd100);
        wait_words(b + 3, 100, "sparse");
        repeat (10) tick();
        n_chk++; if (rx_row.size() !== b + 3) $display("FAIL sparse_words: got %0d want 3", rx_row.size() - b); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (rx_row[b+i] !== er[i] || rx_data[b+i] !== 32'(100 + er[i]) || rx_last[b+i] !== (i == 2))
                $display("FAIL sparse_word%0d: got row %0d data %0d last %b want row %0d data %0d last %b",
                         i, rx_row[b+i], rx_data[b+i], rx_last[b+i], er[i], 100 + er[i], i == 2);
            else n_pass++;
        end
        n_chk++; if (n_pulse - p0 !== 1) $display("FAIL sparse_pulses: got %0d want 1", n_pulse - p0); else n_pass++;
        n_chk++; if (vec_count !== 16'd2) $display("FAIL sparse_count: got %0d want 2", vec_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        int b, p0, lb;
        logic [31:0] base;
        b = rx_row.size();
        p0 = n_pulse;
        lb = last_cyc.size();
        ready_mode = 0;
        tick();
        push_vec(8'hFF, 32'h1000);
        push_vec(8'hFF, 32'h2000);
        push_vec(8'hFF, 32'h3000);
        repeat (30) tick();
        n_chk++; if (n_pulse - p0 !== 2) $display("FAIL bp_pulses_held: got %0d want 2", n_pulse - p0); else n_pass++;
        n_chk++; if (core_outread !== 1'b0) $display("FAIL bp_outread: got %b want 0", core_outread); else n_pass++;
        n_chk++; if (core_rvalid !== 8'hFF) $display("FAIL bp_third_held: rvalid %0h want ff", core_rvalid); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else n_pass++;
        n_chk++; if (vec_count !== 16'd4) $display("FAIL bp_count: got %0d want 4", vec_count); else n_pass++;
        n_chk++; if (out_valid !== 1'b1 || out_row !== 3'd0 || out_data !== 32'h1000)
            $display("FAIL bp_head: got valid %b row %0d data %0h want 1 0 1000", out_valid, out_row, out_data); else n_pass++;
        ready_mode = 1;
        wait_words(b + 24, 200, "bp");
        repeat (5) tick();
        for (int i = 0; i < 24; i++) begin
            base = i < 8 ? 32'h1000 : i < 16 ? 32'h2000 : 32'h3000;
            n_chk++;
            if (rx_row[b+i] !== i % 8 || rx_data[b+i] !== base + 32'(i % 8) || rx_last[b+i] !== (i % 8 == 7))
                $display("FAIL bp_word%0d: got row %0d data %0h want row %0d data %0h",
                         i, rx_row[b+i], rx_data[b+i], i % 8, base + 32'(i % 8));
            else n_pass++;
        end
        n_chk++; if (n_pulse - p0 !== 3) $display("FAIL bp_pulses: got %0d want 3", n_pulse - p0); else n_pass++;
        n_chk++; if (pulse_cyc[p0+2] - last_cyc[lb] !== 2)
            $display("FAIL bp_refill_timing: got %0d want 2", pulse_cyc[p0+2] - last_cyc[lb]); else n_pass++;
        n_chk++; if (vec_count !== 16'd5) $display("FAIL bp_count_end: got %0d want 5", vec_count); else n_pass++;
    endtask

    task automatic test_stall();
        int b, p0, n;
        int e_row[$];
        logic [31:0] e_data[$];
        bit e_last[$];
        logic [7:0] m;
        int left;
        b = rx_row.size();
        p0 = n_pulse;
        ready_mode = 2;
        for (int v = 0; v < 20; v++) begin
            m = 8'((v * 37 + 1) & 255);
            push_vec(m, 32'(v << 8));
            left = $countones(m);
            for (int r = 0; r < 8; r++) if (m[r]) begin
                left--;
                e_row.push_back(r);
                e_data.push_back(32'((v << 8) + r));
                e_last.push_back(left == 0);
            end
        end
        n = e_row.size();
        wait_words(b + n, 4000, "stall");
        ready_mode = 1;
        repeat (10) tick();
        n_chk++; if (rx_row.size() !== b + n) $display("FAIL stall_words: got %0d want %0d", rx_row.size() - b, n); else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (rx_row[b+i] !== e_row[i] || rx_data[b+i] !== e_data[i] || rx_last[b+i] !== e_last[i])
                $display("FAIL stall_word%0d: got row %0d data %0h last %b want row %0d data %0h last %b",
                         i, rx_row[b+i], rx_data[b+i], rx_last[b+i], e_row[i], e_data[i], e_last[i]);
            else n_pass++;
        end
        n_chk++; if (stall_err !== 0) $display("FAIL stall_hold: got %0d unstable holds want 0", stall_err); else n_pass++;
        n_chk++; if (stall_cnt < 1) $display("FAIL stall_seen: got %0d held cycles want >0", stall_cnt); else n_pass++;
        n_chk++; if (n_pulse - p0 !== 20) $display("FAIL stall_pulses: got %0d want 20", n_pulse - p0); else n_pass++;
        n_chk++; if (vec_count !== 16'd25) $display("FAIL stall_count: got %0d want 25", vec_count); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int b, p1, k;
        b = rx_row.size();
        ready_mode = 0;
        tick();
        push_vec(8'hFF, 32'h5000);
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        ready_mode = 1;
        k = 0;
        while (rx_row.size() < b + 3 && k < 50) begin
            tick();
            k++;
        end
        rst = 1'b1;
        ready_mode = 0;
        tick();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL mrst_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (busy !== 1'b0 || vec_count !== 16'd0 || core_outread !== 1'b0)
            $display("FAIL mrst_state: got busy %b count %0d outread %b want 0 0 0", busy, vec_count, core_outread); else n_pass++;
        n_chk++; if (rx_row.size() !== b + 3) $display("FAIL mrst_words: got %0d want 3", rx_row.size() - b); else n_pass++;
        rst = 1'b0;
        p1 = n_pulse;
        repeat (5) tick();
        n_chk++; if (n_pulse !== p1) $display("FAIL mrst_no_ack: got %0d pulses want 0", n_pulse - p1); else n_pass++;
        ready_mode = 1;
        push_vec(8'hFF, 32'h6000);
        wait_words(b + 11, 100, "mrst_new");
        repeat (5) tick();
        n_chk++; if (rx_row[b+3] !== 0 || rx_data[b+3] !== 32'h6000)
            $display("FAIL mrst_first: got row %0d data %0h want 0 6000", rx_row[b+3], rx_data[b+3]); else n_pass++;
        n_chk++; if (rx_row[b+10] !== 7 || rx_last[b+10] !== 1'b1 || rx_data[b+10] !== 32'h6007)
            $display("FAIL mrst_last: got row %0d data %0h last %b want 7 6007 1", rx_row[b+10], rx_data[b+10], rx_last[b+10]); else n_pass++;
        n_chk++; if (vec_count !== 16'd1) $display("FAIL mrst_count: got %0d want 1", vec_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_sparse();
        test_backpressure();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
